// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage.
// ALU opcodes, result classes, writeback constants and divider states.
package ex_stage_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_DIV_CYCLES = 32;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUBU = 8'h23;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_MFHI = 8'h10;
   localparam logic [7:0] OP_MFLO = 8'h12;
   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_MOVE  = 3'b011;
   localparam logic [2:0] SEL_ARITH = 3'b100;

   localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;
   localparam logic       WRITE_EN     = 1'b1;
   localparam logic       WRITE_DIS    = 1'b0;
   localparam logic [4:0] NOP_REG_ADDR = 5'd0;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ON   = 2'd1,
      DIV_END  = 2'd2
   } div_state_t;

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Multi-cycle restoring divider for the execute stage.
// Yields {remainder, quotient} with ready high for one cycle.
module div_core
   import ex_stage_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   op1_i,
   input  logic [DATA_W-1:0]   op2_i,
   input  logic                start_i,
   input  logic                signed_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYCLES - 1);

   div_state_t          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   dend_q;
   logic [DATA_W-1:0]   dsor_q;
   logic [DATA_W-1:0]   rem_q;
   logic [DATA_W-1:0]   quo_q;
   logic                negq_q;
   logic                negr_q;
   logic [2*DATA_W-1:0] result_q;
   logic                ready_q;

   logic [DATA_W-1:0]   abs1;
   logic [DATA_W-1:0]   abs2;
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     diff;
   logic                fits;
   logic [DATA_W-1:0]   rem_d;
   logic [DATA_W-1:0]   quo_d;
   logic [DATA_W-1:0]   rem_fin;
   logic [DATA_W-1:0]   quo_fin;

   // Operand magnitudes and one shift-subtract step.
   always_comb begin
      abs1    = (signed_i && op1_i[DATA_W-1]) ? -op1_i : op1_i;
      abs2    = (signed_i && op2_i[DATA_W-1]) ? -op2_i : op2_i;
      shifted = {rem_q, dend_q[DATA_W-1]};
      diff    = shifted - {1'b0, dsor_q};
      fits    = ~diff[DATA_W];
      rem_d   = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo_d   = {quo_q[DATA_W-2:0], fits};
      quo_fin = negq_q ? -quo_d : quo_d;
      rem_fin = negr_q ? -rem_d : rem_d;
   end

   // Divider FSM; result and ready are registered on entry to DIV_END.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DIV_IDLE;
         cnt_q    <= '0;
         dend_q   <= '0;
         dsor_q   <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else if (annul_i) begin
         state_q <= DIV_IDLE;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               ready_q <= 1'b0;
               if (start_i) begin
                  if (op2_i == '0) begin
                     result_q <= '0;
                     ready_q  <= 1'b1;
                     state_q  <= DIV_END;
                  end else begin
                     dend_q  <= abs1;
                     dsor_q  <= abs2;
                     rem_q   <= '0;
                     quo_q   <= '0;
                     cnt_q   <= '0;
                     negq_q  <= signed_i &
                                (op1_i[DATA_W-1] ^ op2_i[DATA_W-1]);
                     negr_q  <= signed_i & op1_i[DATA_W-1];
                     state_q <= DIV_ON;
                  end
               end
            end
            DIV_ON: begin
               dend_q <= {dend_q[DATA_W-2:0], 1'b0};
               rem_q  <= rem_d;
               quo_q  <= quo_d;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  result_q <= {rem_fin, quo_fin};
                  ready_q  <= 1'b1;
                  state_q  <= DIV_END;
               end
            end
            DIV_END: begin
               ready_q <= 1'b0;
               state_q <= DIV_IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state_q <= DIV_IDLE;
            end
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO, divider control and EX/MEM register.
// Stalls upstream while a divide is in flight.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [7:0]        aluop_i,
   input  logic [2:0]        alusel_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [4:0]        w_addr_i,
   input  logic              we_i,
   output logic [4:0]        w_addr_o,
   output logic              we_o,
   output logic [DATA_W-1:0] w_data_o,
   output logic              stall_req,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic                is_div;
   logic                div_ready;
   logic [2*DATA_W-1:0] div_res;
   logic                hilo_we;

   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] hi_fwd;
   logic [DATA_W-1:0] lo_fwd;

   logic [DATA_W-1:0] logic_res;
   logic [DATA_W-1:0] shift_res;
   logic [DATA_W-1:0] arith_res;
   logic [DATA_W-1:0] move_res;

   logic [4:0]        w_addr_q, w_addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;

   assign is_div    = is_div_op(aluop_i);
   assign hilo_we   = div_ready & ~flush;
   assign stall_req = is_div & ~div_ready & ~flush;
   assign hi_fwd    = hilo_we ? div_res[2*DATA_W-1:DATA_W] : hi_q;
   assign lo_fwd    = hilo_we ? div_res[DATA_W-1:0] : lo_q;

   div_core #(
      .DATA_W     (DATA_W),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .op1_i    (reg1_i),
      .op2_i    (reg2_i),
      .start_i  (is_div),
      .signed_i (aluop_i == OP_DIV),
      .annul_i  (flush),
      .result_o (div_res),
      .ready_o  (div_ready)
   );

   // Per-class results, each zero for opcodes outside its class.
   always_comb begin
      logic_res = '0;
      shift_res = '0;
      arith_res = '0;
      move_res  = '0;
      unique case (1'b1)
         aluop_i == OP_OR:   logic_res = reg1_i | reg2_i;
         aluop_i == OP_AND:  logic_res = reg1_i & reg2_i;
         aluop_i == OP_XOR:  logic_res = reg1_i ^ reg2_i;
         aluop_i == OP_NOR:  logic_res = ~(reg1_i | reg2_i);
         aluop_i == OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
         aluop_i == OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
         aluop_i == OP_SRA:
            shift_res = $signed(reg2_i) >>> reg1_i[4:0];
         aluop_i == OP_ADDU: arith_res = reg1_i + reg2_i;
         aluop_i == OP_SUBU: arith_res = reg1_i - reg2_i;
         aluop_i == OP_SLT:
            arith_res = DATA_W'($signed(reg1_i) < $signed(reg2_i));
         aluop_i == OP_SLTU:
            arith_res = DATA_W'(reg1_i < reg2_i);
         aluop_i == OP_MFHI: move_res = hi_fwd;
         aluop_i == OP_MFLO: move_res = lo_fwd;
         default: ;
      endcase
   end

   // Result mux and bubble insertion for the EX/MEM register.
   always_comb begin
      w_addr_d = w_addr_i;
      we_d     = we_i & ~is_div;
      w_data_d = '0;
      unique case (1'b1)
         alusel_i == SEL_LOGIC: w_data_d = logic_res;
         alusel_i == SEL_SHIFT: w_data_d = shift_res;
         alusel_i == SEL_MOVE:  w_data_d = move_res;
         alusel_i == SEL_ARITH: w_data_d = arith_res;
         default: ;
      endcase
      if (stall_req || flush) begin
         w_addr_d = NOP_REG_ADDR;
         we_d     = WRITE_DIS;
         w_data_d = '0;
      end
   end

   // EX/MEM register and HI/LO update from a finished divide.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_addr_q <= '0;
         we_q     <= 1'b0;
         w_data_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         w_addr_q <= w_addr_d;
         we_q     <= we_d;
         w_data_q <= w_data_d;
         if (hilo_we) begin
            hi_q <= div_res[2*DATA_W-1:DATA_W];
            lo_q <= div_res[DATA_W-1:0];
         end
      end
   end

   assign w_addr_o = w_addr_q;
   assign we_o     = we_q;
   assign w_data_o = w_data_q;
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage.
// Hand-computed vectors for ALU ops, divides, flush and reset.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [7:0]  aluop;
   logic [2:0]  alusel;
   logic [31:0] reg1, reg2;
   logic [4:0]  w_addr;
   logic        we;
   logic [4:0]  w_addr_o;
   logic        we_o;
   logic [31:0] w_data_o;
   logic        stall_req;
   logic [31:0] hi_o, lo_o;

   int total = 0;
   int bad   = 0;

   ex_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .aluop_i   (aluop),
      .alusel_i  (alusel),
      .reg1_i    (reg1),
      .reg2_i    (reg2),
      .w_addr_i  (w_addr),
      .we_i      (we),
      .w_addr_o  (w_addr_o),
      .we_o      (we_o),
      .w_data_o  (w_data_o),
      .stall_req (stall_req),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic wen);
      aluop  = op;
      alusel = sel;
      reg1   = a;
      reg2   = b;
      w_addr = wa;
      we     = wen;
      #1;
   endtask

   task automatic alu(input string tag, input logic [7:0] op,
                      input logic [2:0] sel, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      drive(op, sel, a, b, 5'd9, 1'b1);
      tick();
      chk(tag, w_data_o, exp);
   endtask

   task automatic run_div(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int ncyc, input logic [31:0] ehi,
                          input logic [31:0] elo);
      int n;
      n = 0;
      drive(op, SEL_NOP, a, b, 5'd4, 1'b1);
      while (stall_req && n < 100) begin
         n++;
         tick();
         if (n == 1) chk({tag, "_bubble_we"}, 32'(we_o), 32'd0);
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'(ncyc));
      tick();
      chk({tag, "_we"}, 32'(we_o), 32'd0);
      chk({tag, "_hi"}, hi_o, ehi);
      chk({tag, "_lo"}, lo_o, elo);
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
      tick();
      chk("rst_wdata", w_data_o, 32'd0);
      chk("rst_we", 32'(we_o), 32'd0);
      chk("rst_waddr", 32'(w_addr_o), 32'd0);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      rst = 1'b0;

      drive(OP_OR, SEL_LOGIC, 32'h0000_1100, 32'h0000_0020, 5'd5, 1'b1);
      tick();
      chk("or_data", w_data_o, 32'h0000_1120);
      chk("or_waddr", 32'(w_addr_o), 32'd5);
      chk("or_we", 32'(we_o), 32'd1);

      alu("and", OP_AND, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_00FF,
          32'h00F0_0034);
      alu("xor", OP_XOR, SEL_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000,
          32'h5555_5555);
      alu("nor", OP_NOR, SEL_LOGIC, 32'h0000_00F0, 32'h0000_000F,
          32'hFFFF_FF00);
      alu("sra", OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 32'hF800_0000);
      alu("srl", OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0000, 32'h0800_0000);
      alu("sll", OP_SLL, SEL_SHIFT, 32'h0000_0024, 32'h0000_0003,
          32'h0000_0030);
      alu("slt", OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 32'd1);
      alu("sltu", OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu("subu", OP_SUBU, SEL_ARITH, 32'd0, 32'd1, 32'hFFFF_FFFF);
      alu("badsel", OP_OR, 3'b111, 32'h1234_5678, 32'h1, 32'd0);

      run_div("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
      alu("mflo", OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 32'hFFFF_FFFD);

      run_div("divu", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 33,
              32'h0000_000F, 32'h0FFF_FFFF);
      alu("mfhi", OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 32'h0000_000F);

      run_div("div0", OP_DIV, 32'd5, 32'd0, 1, 32'd0, 32'd0);

      run_div("divu2", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 33,
              32'h0000_000F, 32'h0FFF_FFFF);

      drive(OP_DIV, SEL_NOP, 32'd100, 32'd7, 5'd4, 1'b1);
      for (int i = 0; i < 11; i++) tick();
      chk("pre_flush_stall", 32'(stall_req), 32'd1);
      flush = 1'b1;
      #1;
      chk("flush_stall", 32'(stall_req), 32'd0);
      tick();
      chk("flush_we", 32'(we_o), 32'd0);
      chk("flush_hi", hi_o, 32'h0000_000F);
      chk("flush_lo", lo_o, 32'h0FFF_FFFF);
      flush = 1'b0;
      drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      for (int i = 0; i < 40; i++) tick();
      chk("post_flush_hi", hi_o, 32'h0000_000F);
      chk("post_flush_lo", lo_o, 32'h0FFF_FFFF);

      drive(OP_DIV, SEL_NOP, 32'd100, 32'd7, 5'd4, 1'b1);
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
      chk("mid_rst_wdata", w_data_o, 32'd0);
      chk("mid_rst_we", 32'(we_o), 32'd0);
      chk("mid_rst_waddr", 32'(w_addr_o), 32'd0);
      chk("mid_rst_hi", hi_o, 32'd0);
      chk("mid_rst_lo", lo_o, 32'd0);
      chk("mid_rst_stall", 32'(stall_req), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      chk("post_rst_hi", hi_o, 32'd0);
      chk("post_rst_lo", lo_o, 32'd0);

      drive(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1);
      tick();
      chk("addu_wrap", w_data_o, 32'd0);
      chk("addu_we", 32'(we_o), 32'd1);
      chk("addu_waddr", 32'(w_addr_o), 32'd7);
      alu("addu", OP_ADDU, SEL_ARITH, 32'd2, 32'd3, 32'd5);

      run_div("div_after_rst", OP_DIV, 32'd100, 32'hFFFF_FFF9, 33,
              32'd2, 32'hFFFF_FFF2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
